// File: rtl/mem_port_arbiter_pkg.sv
// Shared widths, word/address types and the arbiter FSM encoding for the
// IF/MEM memory-port arbiter.
package mem_port_arbiter_pkg;

    localparam int WORD_W = 16;
    localparam int ADDR_W = 16;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [ADDR_W-1:0] addr_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_BUSY = 2'd1,
        D_BUSY = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus between the arbiter and the single-port, variable-latency memory.
interface mem_port_arbiter_if;
    import mem_port_arbiter_pkg::*;

    // Handshake: master raises mem_req with mem_we/mem_addr/mem_wdata and holds all
    // four stable until the slave returns a one-cycle mem_ack (mem_rdata valid in
    // that same cycle); mem_req drops on the edge that ends the ack cycle.
    logic  mem_req;
    logic  mem_we;
    addr_t mem_addr;
    word_t mem_wdata;
    word_t mem_rdata;
    logic  mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );

endinterface

// File: rtl/mem_port_arbiter_line_buf.sv
// One-entry {valid, addr, data} result buffer with fill, update-on-match and
// invalidate-on-match, plus a combinational lookup.
module mem_line_buf
    import mem_port_arbiter_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  logic  fill,
    input  addr_t fill_addr,
    input  word_t fill_data,
    input  logic  update,
    input  logic  invalidate,
    input  addr_t match_addr,
    input  word_t update_data,
    input  addr_t lookup_addr,
    output logic  hit,
    output word_t data
);

    logic  valid_q;
    addr_t addr_q;
    word_t data_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else if (fill) begin
            valid_q <= 1'b1;
            addr_q  <= fill_addr;
            data_q  <= fill_data;
        end else begin
            if (update && (addr_q == match_addr))
                data_q <= update_data;
            if (invalidate && (addr_q == match_addr))
                valid_q <= 1'b0;
        end
    end

    assign hit  = valid_q && (addr_q == lookup_addr);
    assign data = data_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the IF fetch port and the MEM load/store port onto one memory,
// producing IF_data_hazard / MEM_data_hazard for the stall logic.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               i_req,
    input  addr_t              i_addr,
    output word_t              i_rdata,
    output logic               IF_data_hazard,
    input  logic               d_read,
    input  logic               d_write,
    input  addr_t              d_addr,
    input  word_t              d_wdata,
    output word_t              d_rdata,
    output logic               MEM_data_hazard,
    input  logic               WB_is_halted,
    mem_port_arbiter_if.master mem,
    output arb_state_t         fsm_state
);

    arb_state_t state_q, state_d;
    logic       req_q, we_q;
    addr_t      addr_q;
    word_t      wdata_q;

    logic       load, load_we;
    addr_t      load_addr;
    word_t      load_wdata;

    logic       ack_i, ack_d;
    logic       ibuf_hit, dbuf_hit;
    word_t      ibuf_data, dbuf_data;
    logic       ihit, dhit, i_bypass, d_bypass;

    assign ack_i    = (state_q == I_BUSY) && mem.mem_ack;
    assign ack_d    = (state_q == D_BUSY) && mem.mem_ack;
    assign ihit     = i_req && ibuf_hit;
    assign dhit     = d_read && dbuf_hit;
    assign i_bypass = ack_i && (addr_q == i_addr);
    assign d_bypass = ack_d && !we_q && d_read && (addr_q == d_addr);

    // MEM port wins in IDLE: it belongs to the older instruction.
    always_comb begin
        state_d    = state_q;
        load       = 1'b0;
        load_we    = 1'b0;
        load_addr  = d_addr;
        load_wdata = d_wdata;
        case (state_q)
            IDLE: begin
                if (!WB_is_halted) begin
                    if (d_write || (d_read && !dbuf_hit)) begin
                        state_d    = D_BUSY;
                        load       = 1'b1;
                        load_we    = d_write;
                        load_addr  = d_addr;
                        load_wdata = d_wdata;
                    end else if (i_req && !ibuf_hit) begin
                        state_d    = I_BUSY;
                        load       = 1'b1;
                        load_addr  = i_addr;
                        load_wdata = '0;
                    end
                end
            end
            I_BUSY, D_BUSY: begin
                if (mem.mem_ack)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                req_q   <= 1'b1;
                we_q    <= load_we;
                addr_q  <= load_addr;
                wdata_q <= load_wdata;
            end else if ((state_q != IDLE) && mem.mem_ack) begin
                req_q <= 1'b0;
                we_q  <= 1'b0;
            end
        end
    end

    // Stores keep dbuf coherent and kill a matching ibuf entry (self-modifying code).
    mem_line_buf u_ibuf (
        .clk         (clk),
        .reset       (reset),
        .fill        (ack_i),
        .fill_addr   (addr_q),
        .fill_data   (mem.mem_rdata),
        .update      (1'b0),
        .invalidate  (ack_d && we_q),
        .match_addr  (addr_q),
        .update_data (wdata_q),
        .lookup_addr (i_addr),
        .hit         (ibuf_hit),
        .data        (ibuf_data)
    );

    mem_line_buf u_dbuf (
        .clk         (clk),
        .reset       (reset),
        .fill        (ack_d && !we_q),
        .fill_addr   (addr_q),
        .fill_data   (mem.mem_rdata),
        .update      (ack_d && we_q),
        .invalidate  (1'b0),
        .match_addr  (addr_q),
        .update_data (wdata_q),
        .lookup_addr (d_addr),
        .hit         (dbuf_hit),
        .data        (dbuf_data)
    );

    assign mem.mem_req   = req_q;
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;

    assign IF_data_hazard  = !reset && i_req && !ihit && !i_bypass;
    assign MEM_data_hazard = !reset && ((d_read && !dhit && !d_bypass) || (d_write && !ack_d));
    assign i_rdata         = reset ? '0 : (i_bypass ? mem.mem_rdata : ibuf_data);
    assign d_rdata         = reset ? '0 : (d_bypass ? mem.mem_rdata : dbuf_data);
    assign fsm_state       = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scenarios plus randomized IF/MEM traffic against a memory model with
// programmable ack delay and a word-level reference memory.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    logic       clk, reset;
    logic       i_req, d_read, d_write, WB_is_halted;
    addr_t      i_addr, d_addr;
    word_t      d_wdata, i_rdata, d_rdata;
    logic       IF_data_hazard, MEM_data_hazard;
    arb_state_t fsm_state;

    mem_port_arbiter_if mem_bus ();

    mem_port_arbiter dut (
        .clk             (clk),
        .reset           (reset),
        .i_req           (i_req),
        .i_addr          (i_addr),
        .i_rdata         (i_rdata),
        .IF_data_hazard  (IF_data_hazard),
        .d_read          (d_read),
        .d_write         (d_write),
        .d_addr          (d_addr),
        .d_wdata         (d_wdata),
        .d_rdata         (d_rdata),
        .MEM_data_hazard (MEM_data_hazard),
        .WB_is_halted    (WB_is_halted),
        .mem             (mem_bus),
        .fsm_state       (fsm_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int          total = 0;
    int          bad   = 0;
    logic [ADDR_W-1:0] exp_q[$];
    word_t       ref_mem[addr_t];
    word_t       mem_store[addr_t];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic word_t mem_init(input addr_t a);
        return (a * 16'h0025) ^ 16'hC3A5;
    endfunction

    function automatic word_t ref_read(input addr_t a);
        return ref_mem.exists(a) ? ref_mem[a] : mem_init(a);
    endfunction

    function automatic word_t mem_rd(input addr_t a);
        return mem_store.exists(a) ? mem_store[a] : mem_init(a);
    endfunction

    function automatic addr_t d_pick(input int r);
        return (r < 8) ? addr_t'(r) : addr_t'(16'h0100 + r - 8);
    endfunction

    // ---------------- memory model ----------------
    int    ack_delay = 1;
    bit    mbusy = 0;
    int    mcnt  = 0;
    addr_t lat_addr;
    logic  lat_we;
    word_t lat_wdata;

    initial begin
        mem_bus.mem_ack   = 1'b0;
        mem_bus.mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            mem_bus.mem_ack = 1'b0;
            if (mbusy) begin
                if (mem_bus.mem_req) begin
                    check_eq("mem_addr_stable", mem_bus.mem_addr, lat_addr);
                    check_eq("mem_we_stable", mem_bus.mem_we, lat_we);
                end
                mcnt--;
                if (mcnt == 0) begin
                    mbusy = 0;
                    mem_bus.mem_ack = 1'b1;
                    if (lat_we) mem_store[lat_addr] = lat_wdata;
                    else        mem_bus.mem_rdata = mem_rd(lat_addr);
                end
            end else if (mem_bus.mem_req && !reset) begin
                lat_addr  = mem_bus.mem_addr;
                lat_we    = mem_bus.mem_we;
                lat_wdata = mem_bus.mem_wdata;
                mcnt      = ack_delay;
                mbusy     = 1;
                if (exp_q.size() > 0)
                    check_eq("mem_addr_seq", mem_bus.mem_addr, exp_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ports(input bit want_i, input bit want_d, input int max,
                              output int ni, output int nd, output word_t ird, output word_t drd);
        bit idone, ddone;
        int c;
        ni = 0; nd = 0; ird = '0; drd = '0; c = 0;
        idone = !want_i;
        ddone = !want_d;
        while (!(idone && ddone) && (c < max)) begin
            @(negedge clk);
            c++;
            if (!idone) begin
                if (IF_data_hazard) ni++;
                else begin idone = 1; ird = i_rdata; end
            end
            if (!ddone) begin
                if (MEM_data_hazard) nd++;
                else begin ddone = 1; drd = d_rdata; end
            end
        end
        check_eq("wait_done", {31'd0, idone && ddone}, 32'd1);
    endtask

    // ---------------- main sequence ----------------
    int    ni, nd, cnt_a, cnt_b;
    word_t ird, drd;

    initial begin
        reset = 1'b1; WB_is_halted = 1'b0;
        i_req = 1'b1; i_addr = 16'h0010;
        d_read = 1'b1; d_write = 1'b0; d_addr = 16'h0200; d_wdata = '0;

        // reset state, with requests present
        @(posedge clk); @(posedge clk); @(negedge clk);
        check_eq("rst_if_haz", IF_data_hazard, 0);
        check_eq("rst_mem_haz", MEM_data_hazard, 0);
        check_eq("rst_i_rdata", i_rdata, 0);
        check_eq("rst_d_rdata", d_rdata, 0);
        check_eq("rst_mem_req", mem_bus.mem_req, 0);
        check_eq("rst_mem_we", mem_bus.mem_we, 0);
        check_eq("rst_mem_addr", mem_bus.mem_addr, 0);
        check_eq("rst_mem_wdata", mem_bus.mem_wdata, 0);
        check_eq("rst_state", fsm_state, IDLE);
        next_cycle;
        reset = 1'b0; i_req = 1'b0; d_read = 1'b0;
        next_cycle;

        // IF miss, N=3
        ack_delay = 3;
        exp_q.push_back(16'h0010);
        i_req = 1'b1; i_addr = 16'h0010;
        wait_ports(1, 0, 50, ni, nd, ird, drd);
        check_eq("ifmiss_cycles", ni, 4);
        check_eq("ifmiss_data", ird, mem_init(16'h0010));
        next_cycle;
        @(negedge clk);
        check_eq("ifhit_haz", IF_data_hazard, 0);
        check_eq("ifhit_req", mem_bus.mem_req, 0);
        check_eq("ifhit_data", i_rdata, mem_init(16'h0010));

        // contention: MEM first, then bubble, then fetch
        next_cycle;
        ack_delay = 2;
        exp_q.push_back(16'h0200);
        exp_q.push_back(16'h0011);
        i_req = 1'b1; i_addr = 16'h0011;
        d_read = 1'b1; d_addr = 16'h0200;
        wait_ports(1, 1, 50, ni, nd, ird, drd);
        check_eq("cont_d_cycles", nd, 3);
        check_eq("cont_i_cycles", ni, 7);
        check_eq("cont_d_data", drd, mem_init(16'h0200));
        check_eq("cont_i_data", ird, mem_init(16'h0011));

        // store coherence on the fetch buffer
        next_cycle;
        ack_delay = 1;
        exp_q.push_back(16'h0011);
        i_req = 1'b0; d_read = 1'b0;
        d_write = 1'b1; d_addr = 16'h0011; d_wdata = 16'hBEEF;
        wait_ports(0, 1, 50, ni, nd, ird, drd);
        check_eq("store_cycles", nd, 2);
        ref_mem[16'h0011] = 16'hBEEF;
        next_cycle;
        exp_q.push_back(16'h0011);
        d_write = 1'b0;
        i_req = 1'b1; i_addr = 16'h0011;
        wait_ports(1, 0, 50, ni, nd, ird, drd);
        check_eq("refetch_cycles", ni, 2);
        check_eq("refetch_data", ird, 16'hBEEF);

        // redirect mid-fetch
        next_cycle;
        ack_delay = 3;
        exp_q.push_back(16'h0020);
        exp_q.push_back(16'h0040);
        i_addr = 16'h0020;
        next_cycle;
        next_cycle;
        i_addr = 16'h0040;
        wait_ports(1, 0, 50, ni, nd, ird, drd);
        check_eq("redir_cycles", ni, 7);
        check_eq("redir_data", ird, mem_init(16'h0040));

        // halt during I_BUSY
        next_cycle;
        exp_q.push_back(16'h0030);
        i_addr = 16'h0030;
        next_cycle;
        WB_is_halted = 1'b1;
        d_read = 1'b1; d_addr = 16'h0300;
        wait_ports(1, 0, 50, ni, nd, ird, drd);
        check_eq("halt_if_cycles", ni, 3);
        check_eq("halt_if_data", ird, mem_init(16'h0030));
        cnt_a = 0; cnt_b = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (mem_bus.mem_req) cnt_a++;
            if (MEM_data_hazard) cnt_b++;
        end
        check_eq("halt_no_req", cnt_a, 0);
        check_eq("halt_d_stalled", cnt_b, 10);
        next_cycle;
        exp_q.push_back(16'h0300);
        WB_is_halted = 1'b0;
        wait_ports(0, 1, 50, ni, nd, ird, drd);
        check_eq("unhalt_d_cycles", nd, 4);
        check_eq("unhalt_d_data", drd, mem_init(16'h0300));

        // reset while D_BUSY, late ack ignored, buffers cleared
        next_cycle;
        ack_delay = 4;
        exp_q.push_back(16'h0400);
        i_req = 1'b0;
        d_addr = 16'h0400;
        next_cycle;
        @(negedge clk);
        check_eq("pre_rst_req", mem_bus.mem_req, 1);
        check_eq("pre_rst_state", fsm_state, D_BUSY);
        next_cycle;
        reset = 1'b1;
        @(negedge clk);
        check_eq("mid_rst_req", mem_bus.mem_req, 0);
        check_eq("mid_rst_haz", MEM_data_hazard, 0);
        check_eq("mid_rst_state", fsm_state, IDLE);
        next_cycle;
        reset = 1'b0; d_read = 1'b0;
        cnt_a = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (mem_bus.mem_req || (fsm_state != IDLE)) cnt_a++;
        end
        check_eq("late_ack_ignored", cnt_a, 0);
        next_cycle;
        ack_delay = 1;
        exp_q.push_back(16'h0400);
        exp_q.push_back(16'h0030);
        d_read = 1'b1; d_addr = 16'h0400;
        i_req = 1'b1; i_addr = 16'h0030;
        wait_ports(1, 1, 50, ni, nd, ird, drd);
        check_eq("post_rst_d_cycles", nd, 2);
        check_eq("post_rst_i_cycles", ni, 5);
        check_eq("post_rst_d_data", drd, mem_init(16'h0400));
        check_eq("post_rst_i_data", ird, mem_init(16'h0030));
        check_eq("exp_q_empty", exp_q.size(), 0);

        // randomized traffic against the reference memory
        begin
            bit    if_act, d_act;
            int    if_wait, d_wait;
            bit    d_is_wr;
            addr_t if_a, d_a;
            word_t d_w;
            if_act = 0; d_act = 0; if_wait = 0; d_wait = 0;
            d_is_wr = 0; if_a = '0; d_a = '0; d_w = '0;
            for (int cyc = 0; cyc < 3000; cyc++) begin
                next_cycle;
                ack_delay = $urandom_range(1, 4);
                if (!if_act) begin
                    if ($urandom_range(0, 2) != 0) begin
                        if_act = 1; if_wait = 0;
                        if_a = addr_t'($urandom_range(0, 7));
                    end
                end else if ($urandom_range(0, 15) == 0) begin
                    if_a = addr_t'($urandom_range(0, 7));
                end
                if (!d_act && ($urandom_range(0, 1) == 0)) begin
                    d_act = 1; d_wait = 0;
                    d_is_wr = ($urandom_range(0, 1) == 1);
                    d_a = d_pick($urandom_range(0, 11));
                    d_w = word_t'($urandom);
                end
                i_req = if_act; i_addr = if_a;
                d_read = d_act && !d_is_wr; d_write = d_act && d_is_wr;
                d_addr = d_a; d_wdata = d_w;
                @(negedge clk);
                if (if_act) begin
                    if (!IF_data_hazard) begin
                        check_eq("rnd_i_rdata", i_rdata, ref_read(if_a));
                        if_act = 0;
                    end else if (++if_wait > 200) begin
                        check_eq("rnd_i_timeout", if_wait, 0);
                        if_act = 0;
                    end
                end
                if (d_act) begin
                    if (!MEM_data_hazard) begin
                        if (d_is_wr) ref_mem[d_a] = d_w;
                        else check_eq("rnd_d_rdata", d_rdata, ref_read(d_a));
                        d_act = 0;
                    end else if (++d_wait > 200) begin
                        check_eq("rnd_d_timeout", d_wait, 0);
                        d_act = 0;
                    end
                end
            end
        end
        next_cycle;
        i_req = 1'b0; d_read = 1'b0; d_write = 1'b0;
        repeat (8) @(posedge clk);
        for (int r = 0; r < 12; r++)
            check_eq("mem_final", mem_rd(d_pick(r)), ref_read(d_pick(r)));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
